// File: rtl/sound_glu.sv
// -----------------------------------------------------------------------------
// sound_glu
//
// CPU-side Sound GLU for the ES5503 DOC.
//
// The 64 KB sound RAM is time-shared between the DOC sample fetch and CPU
// accesses by a fixed slot scheduler. Every oscillator slot is SLOT_LEN clocks
// long:
//   cycle 0                : sample fetch, ram_addr = DOC addr_out
//   cycle 1                : fetched byte captured into doc_sample_data
//   cycle 2                : doc_osc_en pulse (DOC advances to next oscillator)
//   cycles 3..SLOT_LEN-1   : CPU window. An op may start in 3..SLOT_LEN-2, so
//                            its second cycle always fits in the same slot.
//
// The CPU sees four byte registers:
//   0 control  : [7] busy (RO), [6] 1=RAM / 0=DOC, [5] auto-increment,
//                [4] reads 0, [3:0] volume (stored only)
//   1 data     : access queues one RAM / DOC-register op (dummy-read model)
//   2 addr lo  : address bits [7:0]
//   3 addr hi  : address bits [15:8]
//
// A data op runs in two cycles: cycle A presents the address (and write data),
// cycle B captures read data and optionally auto-increments the address.
//
// Parameters:
//   SLOT_LEN  clk cycles per oscillator slot, legal range 6..32
//   PARK_REG  DOC register address driven when no op is in cycle A
//             (must never be the OIR, $E0, since reading it pops the IRQ stack)
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   cpu_strobe        one-cycle CPU access to a GLU register
//   cpu_we            1=write, 0=read (qualified by cpu_strobe)
//   cpu_addr[1:0]     GLU register select
//   cpu_din[7:0]      CPU write data
//   cpu_dout[7:0]     combinational read of the register selected by cpu_addr
//   doc_addr_in[16:0] DOC addr_out; [15:0] is the sample fetch address
//   doc_data_in[7:0]  DOC register read data, valid the cycle after the address
//   doc_osc_en        one-cycle DOC advance pulse per slot
//   doc_wr            DOC register write strobe
//   doc_reg_addr[7:0] DOC register address
//   doc_reg_dout[7:0] DOC register write data
//   doc_sample_data   sample byte to the DOC
//   ram_addr[15:0]    sound RAM address (synchronous RAM, 1-cycle read latency)
//   ram_we            sound RAM write enable
//   ram_din[7:0]      sound RAM write data
//   ram_dout[7:0]     sound RAM read data
// -----------------------------------------------------------------------------
module sound_glu #(
    parameter int          SLOT_LEN = 8,
    parameter logic [7:0]  PARK_REG = 8'h40
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cpu_strobe,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,

    input  logic [16:0] doc_addr_in,
    input  logic [7:0]  doc_data_in,
    output logic        doc_osc_en,
    output logic        doc_wr,
    output logic [7:0]  doc_reg_addr,
    output logic [7:0]  doc_reg_dout,
    output logic [7:0]  doc_sample_data,

    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // Five bits cover the largest legal slot length (32 -> 0..31).
    localparam int SLOT_W = 5;

    localparam logic [SLOT_W-1:0] SLOT_FETCH  = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_SAMPLE = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_OSC    = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] SLOT_FIRST  = SLOT_W'(3);
    localparam logic [SLOT_W-1:0] SLOT_LSTART = SLOT_W'(SLOT_LEN - 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SLOT_LEN - 1);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DATA    = 2'd1;
    localparam logic [1:0] REG_ADDR_LO = 2'd2;
    localparam logic [1:0] REG_ADDR_HI = 2'd3;

    // Op sequencer:
    //   ST_IDLE   : no op outstanding
    //   ST_PEND   : op requested; the cycle in which the slot counter is inside
    //               the start window is cycle A
    //   ST_EXEC_B : cycle B (read capture, auto-increment, release busy)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_EXEC_B = 2'd2
    } op_state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [SLOT_W-1:0] r_slot;
    op_state_t         r_state;

    logic              r_ctrl_ram;     // control[6]
    logic              r_ctrl_ainc;    // control[5]
    logic [3:0]        r_ctrl_vol;     // control[3:0]

    logic [15:0]       r_addr;
    logic [7:0]        r_data_latch;
    logic [7:0]        r_sample;

    // Request-time snapshot; later CPU register writes never disturb an op
    // that is already queued.
    logic [15:0]       r_snap_addr;
    logic              r_snap_we;
    logic              r_snap_ram;
    logic [7:0]        r_snap_din;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    op_state_t         w_state_nxt;
    logic              w_busy;
    logic              w_in_window;
    logic              w_cycle_a;
    logic              w_fetch;
    logic              w_data_req;
    logic              w_ctrl_wr;
    logic              w_addr_lo_wr;
    logic              w_addr_hi_wr;
    logic              w_unused;

    // busy and pending are the same condition: an op is outstanding from the
    // request edge until the end of its cycle B.
    assign w_busy      = (r_state != ST_IDLE);

    assign w_in_window = (r_slot >= SLOT_FIRST) && (r_slot <= SLOT_LSTART);
    assign w_cycle_a   = (r_state == ST_PEND) && w_in_window;

    // The fetch address is gated by reset so that every output except
    // doc_reg_addr reads zero while the block is held in reset.
    assign w_fetch     = (r_slot == SLOT_FETCH) && reset_n;

    // A data access while busy is silently dropped.
    assign w_data_req   = cpu_strobe && (cpu_addr == REG_DATA) && !w_busy;
    assign w_ctrl_wr    = cpu_strobe && cpu_we && (cpu_addr == REG_CTRL);
    assign w_addr_lo_wr = cpu_strobe && cpu_we && (cpu_addr == REG_ADDR_LO);
    assign w_addr_hi_wr = cpu_strobe && cpu_we && (cpu_addr == REG_ADDR_HI);

    // Bit 16 of the DOC address selects the upper bank, which this GLU does
    // not implement.
    assign w_unused = doc_addr_in[16];

    // -------------------------------------------------------------------------
    // Op sequencer: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together on the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Op sequencer: next state and bus outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        ram_addr     = 16'h0000;
        ram_we       = 1'b0;
        ram_din      = 8'h00;
        doc_wr       = 1'b0;
        doc_reg_addr = PARK_REG;
        doc_reg_dout = 8'h00;

        unique case (r_state)
            ST_IDLE: begin
                if (w_data_req) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_in_window) begin
                    w_state_nxt = ST_EXEC_B;
                end
            end
            ST_EXEC_B: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Cycle A can never coincide with slot cycle 0, so the fetch address
        // and the CPU address never compete for ram_addr.
        if (w_fetch) begin
            ram_addr = doc_addr_in[15:0];
        end else if (w_cycle_a && r_snap_ram) begin
            ram_addr = r_snap_addr;
            ram_we   = r_snap_we;
            ram_din  = r_snap_we ? r_snap_din : 8'h00;
        end

        // The DOC register address leaves PARK_REG for exactly one cycle, so a
        // read of the OIR pops the DOC IRQ stack once.
        if (w_cycle_a && !r_snap_ram) begin
            doc_reg_addr = r_snap_addr[7:0];
            doc_wr       = r_snap_we;
            doc_reg_dout = r_snap_we ? r_snap_din : 8'h00;
        end
    end

    // -------------------------------------------------------------------------
    // Slot counter and sample path
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot   <= SLOT_FETCH;
            r_sample <= 8'h00;
        end else begin
            r_slot <= (r_slot == SLOT_LAST) ? SLOT_FETCH : r_slot + SLOT_W'(1);
            // RAM data for the cycle-0 fetch address is valid during cycle 1.
            if (r_slot == SLOT_SAMPLE) begin
                r_sample <= ram_dout;
            end
        end
    end

    assign doc_osc_en      = (r_slot == SLOT_OSC);
    assign doc_sample_data = r_sample;

    // -------------------------------------------------------------------------
    // CPU register file and request snapshot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_ram   <= 1'b0;
            r_ctrl_ainc  <= 1'b0;
            r_ctrl_vol   <= 4'h0;
            r_addr       <= 16'h0000;
            r_data_latch <= 8'h00;
            r_snap_addr  <= 16'h0000;
            r_snap_we    <= 1'b0;
            r_snap_ram   <= 1'b0;
            r_snap_din   <= 8'h00;
        end else begin
            // Busy (bit 7) is status only; bit 4 is not stored.
            if (w_ctrl_wr) begin
                r_ctrl_ram  <= cpu_din[6];
                r_ctrl_ainc <= cpu_din[5];
                r_ctrl_vol  <= cpu_din[3:0];
            end

            if (w_data_req) begin
                r_snap_addr <= r_addr;
                r_snap_we   <= cpu_we;
                r_snap_ram  <= r_ctrl_ram;
                r_snap_din  <= cpu_din;
            end

            // A CPU address write in the same cycle as an auto-increment wins
            // and the increment is discarded.
            if (w_addr_lo_wr || w_addr_hi_wr) begin
                if (w_addr_lo_wr) begin
                    r_addr[7:0] <= cpu_din;
                end
                if (w_addr_hi_wr) begin
                    r_addr[15:8] <= cpu_din;
                end
            end else if ((r_state == ST_EXEC_B) && r_ctrl_ainc) begin
                r_addr <= r_snap_addr + 16'd1;
            end

            // Cycle B: RAM data follows the cycle-A address by one clock, and
            // DOC register data is valid the cycle after doc_reg_addr.
            if ((r_state == ST_EXEC_B) && !r_snap_we) begin
                r_data_latch <= r_snap_ram ? ram_dout : doc_data_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU read mux
    // -------------------------------------------------------------------------
    // A data-register read returns the byte fetched by the previous op; the
    // byte for the current address arrives when the op it queues completes.
    always_comb begin
        cpu_dout = 8'h00;
        unique case (cpu_addr)
            REG_CTRL:    cpu_dout = {w_busy, r_ctrl_ram, r_ctrl_ainc, 1'b0, r_ctrl_vol};
            REG_DATA:    cpu_dout = r_data_latch;
            REG_ADDR_LO: cpu_dout = r_addr[7:0];
            REG_ADDR_HI: cpu_dout = r_addr[15:8];
            default:     cpu_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_sound_glu.sv
// -----------------------------------------------------------------------------
// tb_sound_glu
//
// Directed bench for sound_glu (SLOT_LEN = 8, PARK_REG = $40). Surrounds the
// GLU with a synchronous 64 KB RAM and a 256-entry DOC register file, runs a
// table of register-window vectors, then hand-written sequences for slot
// pacing, the op window edges, DOC access, address wrap, busy drop and reset
// during an op.
// -----------------------------------------------------------------------------
module tb_sound_glu;

    logic        clk;
    logic        reset_n;
    logic        cpu_strobe;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [16:0] doc_addr_in;
    logic [7:0]  doc_data_in;
    logic        doc_osc_en;
    logic        doc_wr;
    logic [7:0]  doc_reg_addr;
    logic [7:0]  doc_reg_dout;
    logic [7:0]  doc_sample_data;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    sound_glu #(
        .SLOT_LEN (8),
        .PARK_REG (8'h40)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cpu_strobe      (cpu_strobe),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .doc_addr_in     (doc_addr_in),
        .doc_data_in     (doc_data_in),
        .doc_osc_en      (doc_osc_en),
        .doc_wr          (doc_wr),
        .doc_reg_addr    (doc_reg_addr),
        .doc_reg_dout    (doc_reg_dout),
        .doc_sample_data (doc_sample_data),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_din         (ram_din),
        .ram_dout        (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- models
    logic [7:0]  mem [0:65535];
    logic        pre_ram_we;
    logic [15:0] pre_ram_addr;
    logic [7:0]  pre_ram_din;

    always @(posedge clk) begin
        if (pre_ram_we) mem[pre_ram_addr] <= pre_ram_din;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    logic [7:0] doc_regs [0:255];
    logic       pre_doc_we;
    logic [7:0] pre_doc_addr;
    logic [7:0] pre_doc_din;

    always @(posedge clk) begin
        if (pre_doc_we) doc_regs[pre_doc_addr] <= pre_doc_din;
        else if (doc_wr) doc_regs[doc_reg_addr] <= doc_reg_dout;
        doc_data_in <= doc_regs[doc_reg_addr];
    end

    // Expected slot position, tracked independently from the DUT.
    int tb_slot;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_slot <= 0;
        else          tb_slot <= (tb_slot == 7) ? 0 : tb_slot + 1;
    end

    // Event counters, sampled on the clock edge that acts on the signals.
    int we_cnt, dw_cnt, e0_cnt;
    initial begin
        we_cnt = 0; dw_cnt = 0; e0_cnt = 0;
    end
    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (doc_wr) dw_cnt <= dw_cnt + 1;
        if (doc_reg_addr == 8'hE0) e0_cnt <= e0_cnt + 1;
    end

    // ---------------------------------------------------------------- helpers
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic preload_ram(input logic [15:0] a, input logic [7:0] d);
        pre_ram_addr = a; pre_ram_din = d; pre_ram_we = 1'b1;
        @(posedge clk); #1;
        pre_ram_we = 1'b0;
    endtask

    task automatic preload_doc(input logic [7:0] a, input logic [7:0] d);
        pre_doc_addr = a; pre_doc_din = d; pre_doc_we = 1'b1;
        @(posedge clk); #1;
        pre_doc_we = 1'b0;
    endtask

    // One-cycle register access; returns cpu_dout seen in the request cycle.
    task automatic cpu_op(input logic [1:0] a, input logic we, input logic [7:0] d,
                          output logic [7:0] rd);
        cpu_strobe = 1'b1; cpu_addr = a; cpu_we = we; cpu_din = d;
        #1;
        rd = cpu_dout;
        @(negedge clk);
        cpu_strobe = 1'b0; cpu_we = 1'b0; cpu_din = 8'h00;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] v);
        cpu_addr = a;
        #1;
        v = cpu_dout;
    endtask

    task automatic wait_slot(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (tb_slot != k && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeout("wait_slot");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        cpu_addr = 2'd0;
        #1;
        while (cpu_dout[7] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("wait_idle");
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct packed {
        logic [1:0] addr;
        logic       we;
        logic [7:0] din;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    logic [7:0] rd, v;
    int base, first, second, pulses, bad_park;

    initial begin
        // Register window and dummy-read vectors {addr, we, din, chk, exp}.
        vec[0]  = '{2'd0, 1'b1, 8'hFF, 1'b0, 8'h00};  // control: bit 7 ignored
        vec[1]  = '{2'd0, 1'b0, 8'h00, 1'b1, 8'h6F};  // bit 4 reads 0
        vec[2]  = '{2'd0, 1'b1, 8'h10, 1'b0, 8'h00};
        vec[3]  = '{2'd0, 1'b0, 8'h00, 1'b1, 8'h00};
        vec[4]  = '{2'd2, 1'b1, 8'h00, 1'b0, 8'h00};  // addr = $0100
        vec[5]  = '{2'd3, 1'b1, 8'h01, 1'b0, 8'h00};
        vec[6]  = '{2'd2, 1'b0, 8'h00, 1'b1, 8'h00};
        vec[7]  = '{2'd3, 1'b0, 8'h00, 1'b1, 8'h01};
        vec[8]  = '{2'd0, 1'b1, 8'h60, 1'b0, 8'h00};  // RAM, auto-increment
        vec[9]  = '{2'd0, 1'b0, 8'h00, 1'b1, 8'h60};
        vec[10] = '{2'd1, 1'b0, 8'h00, 1'b1, 8'h00};  // dummy read: old latch
        vec[11] = '{2'd1, 1'b0, 8'h00, 1'b1, 8'h11};
        vec[12] = '{2'd1, 1'b0, 8'h00, 1'b1, 8'h22};
        vec[13] = '{2'd2, 1'b0, 8'h00, 1'b1, 8'h03};  // addr ends at $0103
        vec[14] = '{2'd3, 1'b0, 8'h00, 1'b1, 8'h01};

        n_checks = 0; n_fail = 0;
        reset_n = 1'b0;
        cpu_strobe = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
        doc_addr_in = 17'h1_5A5A;
        pre_ram_we = 1'b0; pre_ram_addr = 16'h0; pre_ram_din = 8'h0;
        pre_doc_we = 1'b0; pre_doc_addr = 8'h0;  pre_doc_din = 8'h0;

        preload_ram(16'h5A5A, 8'hC3);
        preload_ram(16'h0100, 8'h11);
        preload_ram(16'h0101, 8'h22);
        preload_ram(16'h3001, 8'h00);
        preload_ram(16'h4000, 8'h00);
        preload_doc(8'hA0, 8'hFF);
        preload_doc(8'hE0, 8'h5C);

        // ------------------------------------------------ reset and pacing
        @(negedge clk);
        check("rst_osc_en",   {31'd0, doc_osc_en}, 32'd0);
        check("rst_ram_we",   {31'd0, ram_we},     32'd0);
        check("rst_doc_wr",   {31'd0, doc_wr},     32'd0);
        check("rst_reg_addr", {24'd0, doc_reg_addr}, 32'h40);
        check("rst_ram_addr", {16'd0, ram_addr},   32'd0);
        check("rst_others",   {8'd0, doc_sample_data, ram_din, doc_reg_dout}, 32'd0);
        check("rst_cpu_dout", {24'd0, cpu_dout},   32'd0);

        reset_n = 1'b1;
        #1;
        check("slot0_ram_addr", {16'd0, ram_addr}, 32'h5A5A);
        check("slot0_osc_en",   {31'd0, doc_osc_en}, 32'd0);
        @(negedge clk);
        check("slot1_osc_en",   {31'd0, doc_osc_en}, 32'd0);
        @(negedge clk);
        check("slot2_osc_en",   {31'd0, doc_osc_en}, 32'd1);
        check("slot2_sample",   {24'd0, doc_sample_data}, 32'hC3);
        check("slot2_reg_addr", {24'd0, doc_reg_addr}, 32'h40);

        first = -1; second = -1; pulses = 0; bad_park = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (doc_osc_en) begin
                pulses++;
                if (first < 0) first = i;
                else           second = i;
            end
            if (doc_reg_addr != 8'h40) bad_park++;
        end
        check("osc_pulse_count",  pulses,   32'd2);
        check("osc_pulse_first",  first,    32'd7);
        check("osc_pulse_second", second,   32'd15);
        check("park_held",        bad_park, 32'd0);

        // ------------------------------------------------ table vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            cpu_op(vec[i].addr, vec[i].we, vec[i].din, rd);
            if (vec[i].chk) check($sformatf("vec%0d", i), {24'd0, rd}, {24'd0, vec[i].exp});
            if (vec[i].addr == 2'd1) wait_idle();
        end

        // ------------------------------------------------ RAM write, auto-inc
        @(negedge clk);
        cpu_op(2'd0, 1'b1, 8'h60, rd);
        cpu_op(2'd2, 1'b1, 8'hFF, rd);
        cpu_op(2'd3, 1'b1, 8'h12, rd);
        wait_slot(2);
        base = we_cnt;
        cpu_op(2'd1, 1'b1, 8'hAB, rd);            // now slot 3 = cycle A
        check("wr_a_ram_we",   {31'd0, ram_we},   32'd1);
        check("wr_a_ram_addr", {16'd0, ram_addr}, 32'h12FF);
        check("wr_a_ram_din",  {24'd0, ram_din},  32'hAB);
        check("wr_a_doc_wr",   {31'd0, doc_wr},   32'd0);
        peek(2'd0, v);
        check("wr_busy",       {24'd0, v},        32'hE0);
        @(negedge clk);
        check("wr_b_ram_we",   {31'd0, ram_we},   32'd0);
        wait_idle();
        @(negedge clk);
        check("wr_we_pulses",  we_cnt - base,     32'd1);
        check("wr_mem",        {24'd0, mem[16'h12FF]}, 32'hAB);
        peek(2'd2, v); check("wr_addr_lo", {24'd0, v}, 32'h00);
        peek(2'd3, v); check("wr_addr_hi", {24'd0, v}, 32'h13);
        peek(2'd0, v); check("wr_ctrl",    {24'd0, v}, 32'h60);

        // ------------------------------------------------ DOC path
        @(negedge clk);
        cpu_op(2'd0, 1'b1, 8'h00, rd);
        cpu_op(2'd2, 1'b1, 8'hA0, rd);
        wait_slot(2);
        base = dw_cnt;
        cpu_op(2'd1, 1'b1, 8'h00, rd);            // slot 3
        check("doc_a_wr",       {31'd0, doc_wr},       32'd1);
        check("doc_a_reg_addr", {24'd0, doc_reg_addr}, 32'hA0);
        check("doc_a_reg_dout", {24'd0, doc_reg_dout}, 32'h00);
        check("doc_a_ram_we",   {31'd0, ram_we},       32'd0);
        @(negedge clk);
        check("doc_b_wr",       {31'd0, doc_wr},       32'd0);
        check("doc_b_reg_addr", {24'd0, doc_reg_addr}, 32'h40);
        wait_idle();
        @(negedge clk);
        check("doc_wr_pulses",  dw_cnt - base,         32'd1);
        check("doc_reg_a0",     {24'd0, doc_regs[8'hA0]}, 32'h00);

        cpu_op(2'd2, 1'b1, 8'hE0, rd);
        wait_slot(2);
        base = e0_cnt;
        cpu_op(2'd1, 1'b0, 8'h00, rd);            // slot 3
        check("oir_a_reg_addr", {24'd0, doc_reg_addr}, 32'hE0);
        @(negedge clk);
        check("oir_b_reg_addr", {24'd0, doc_reg_addr}, 32'h40);
        wait_idle();
        repeat (3) @(negedge clk);
        check("oir_cycles",     e0_cnt - base,         32'd1);
        peek(2'd1, v);
        check("oir_latch",      {24'd0, v},            32'h5C);

        // ------------------------------------------------ window edges
        @(negedge clk);
        cpu_op(2'd0, 1'b1, 8'h60, rd);
        cpu_op(2'd2, 1'b1, 8'h00, rd);
        cpu_op(2'd3, 1'b1, 8'h20, rd);
        wait_slot(1);
        cpu_op(2'd1, 1'b1, 8'h77, rd);            // request at slot 1, now slot 2
        check("e1_s2_ram_we",   {31'd0, ram_we},     32'd0);
        check("e1_s2_osc_en",   {31'd0, doc_osc_en}, 32'd1);
        @(negedge clk);
        check("e1_s3_ram_we",   {31'd0, ram_we},     32'd1);
        check("e1_s3_ram_addr", {16'd0, ram_addr},   32'h2000);
        check("e1_s3_ram_din",  {24'd0, ram_din},    32'h77);
        wait_idle();
        wait_slot(6);
        cpu_op(2'd1, 1'b1, 8'h88, rd);            // request at slot 6, now slot 7
        check("e6_s7_ram_we",   {31'd0, ram_we},     32'd0);
        @(negedge clk);
        check("e6_s0_ram_addr", {16'd0, ram_addr},   32'h5A5A);
        check("e6_s0_ram_we",   {31'd0, ram_we},     32'd0);
        @(negedge clk);
        check("e6_s1_ram_we",   {31'd0, ram_we},     32'd0);
        @(negedge clk);
        check("e6_s2_osc_en",   {31'd0, doc_osc_en}, 32'd1);
        check("e6_s2_ram_we",   {31'd0, ram_we},     32'd0);
        check("e6_s2_sample",   {24'd0, doc_sample_data}, 32'hC3);
        @(negedge clk);
        check("e6_s3_ram_we",   {31'd0, ram_we},     32'd1);
        check("e6_s3_ram_addr", {16'd0, ram_addr},   32'h2001);
        check("e6_s3_ram_din",  {24'd0, ram_din},    32'h88);
        wait_idle();
        @(negedge clk);
        check("edge_mem_2000",  {24'd0, mem[16'h2000]}, 32'h77);
        check("edge_mem_2001",  {24'd0, mem[16'h2001]}, 32'h88);

        // ------------------------------------------------ address wrap
        @(negedge clk);
        cpu_op(2'd2, 1'b1, 8'hFF, rd);
        cpu_op(2'd3, 1'b1, 8'hFF, rd);
        wait_slot(2);
        cpu_op(2'd1, 1'b1, 8'h5E, rd);
        wait_idle();
        @(negedge clk);
        peek(2'd2, v); check("wrap_addr_lo", {24'd0, v}, 32'h00);
        peek(2'd3, v); check("wrap_addr_hi", {24'd0, v}, 32'h00);
        check("wrap_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h5E);

        // ------------------------------------------------ busy drop
        @(negedge clk);
        cpu_op(2'd2, 1'b1, 8'h00, rd);
        cpu_op(2'd3, 1'b1, 8'h30, rd);
        wait_slot(6);
        base = we_cnt;
        cpu_op(2'd1, 1'b1, 8'h99, rd);            // accepted, now slot 7
        cpu_op(2'd1, 1'b1, 8'hAA, rd);            // busy: dropped
        wait_idle();
        @(negedge clk);
        check("drop_we_pulses", we_cnt - base,          32'd1);
        check("drop_mem_3000",  {24'd0, mem[16'h3000]}, 32'h99);
        check("drop_mem_3001",  {24'd0, mem[16'h3001]}, 32'h00);
        peek(2'd2, v); check("drop_addr_lo", {24'd0, v}, 32'h01);
        peek(2'd3, v); check("drop_addr_hi", {24'd0, v}, 32'h30);

        // ------------------------------------------------ reset in cycle A
        @(negedge clk);
        cpu_op(2'd2, 1'b1, 8'h00, rd);
        cpu_op(2'd3, 1'b1, 8'h40, rd);
        wait_slot(2);
        base = we_cnt;
        cpu_op(2'd1, 1'b1, 8'hE7, rd);            // slot 3 = cycle A
        check("rsta_ram_we_before", {31'd0, ram_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rsta_ram_we_in_rst", {31'd0, ram_we}, 32'd0);
        peek(2'd0, v);
        check("rsta_busy_in_rst",   {24'd0, v},      32'h00);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rsta_we_pulses",     we_cnt - base,   32'd0);
        check("rsta_mem_4000",      {24'd0, mem[16'h4000]}, 32'h00);
        peek(2'd0, v); check("rsta_ctrl_after",  {24'd0, v}, 32'h00);
        peek(2'd3, v); check("rsta_addr_hi",     {24'd0, v}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
